// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the KONAMI-1 core: shift/rotate opcodes, the
// shift-sequencer state encoding and the condition-code bit layout.
package jtkcpu_pkg;

    // Count-operand shift/rotate opcodes, memory-word (W) and D forms
    localparam logic [7:0] OP_LSRW  = 8'hA3;
    localparam logic [7:0] OP_RORW  = 8'hA4;
    localparam logic [7:0] OP_ASRW  = 8'hA5;
    localparam logic [7:0] OP_ASLW  = 8'hA6;
    localparam logic [7:0] OP_ROLW  = 8'hA7;
    localparam logic [7:0] OP_LSRD  = 8'hB8;
    localparam logic [7:0] OP_LSRDI = 8'hB9;
    localparam logic [7:0] OP_RORD  = 8'hBA;
    localparam logic [7:0] OP_RORDI = 8'hBB;
    localparam logic [7:0] OP_ASRD  = 8'hBC;
    localparam logic [7:0] OP_ASRDI = 8'hBD;
    localparam logic [7:0] OP_ASLD  = 8'hBE;
    localparam logic [7:0] OP_ASLDI = 8'hBF;
    localparam logic [7:0] OP_ROLD  = 8'hC0;
    localparam logic [7:0] OP_ROLDI = 8'hC1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CC_C = 0;
    localparam int CC_V = 1;
    localparam int CC_Z = 2;
    localparam int CC_N = 3;
    localparam int CC_I = 4;
    localparam int CC_H = 5;
    localparam int CC_F = 6;
    localparam int CC_E = 7;

    // Bits the ALU is allowed to change during a shift step
    localparam logic [7:0] CC_ALU_MASK = (8'd1 << CC_C) | (8'd1 << CC_V) |
                                         (8'd1 << CC_Z) | (8'd1 << CC_N);

    localparam logic [7:0] SAT_LIMIT = 8'd17;

    // C/V/N/Z from the ALU, every other bit kept from the running CC
    function automatic logic [7:0] cc_merge(input logic [7:0] alu_cc,
                                            input logic [7:0] keep_cc);
        return (alu_cc & CC_ALU_MASK) | (keep_cc & ~CC_ALU_MASK);
    endfunction

endpackage

// File: rtl/jtkcpu_shseq_dec.sv
// Opcode decoder for the shift sequencer: flags supported opcodes and the
// LSR/ASL/ASR family whose step count may be clamped.
module jtkcpu_shseq_dec
    import jtkcpu_pkg::*;
(
    input  logic [7:0] op,
    output logic       valid,
    output logic       sat_ok
);

    always_comb begin
        valid  = 1'b0;
        sat_ok = 1'b0;
        case (op)
            OP_LSRW, OP_ASRW, OP_ASLW,
            OP_LSRD, OP_LSRDI, OP_ASRD, OP_ASRDI, OP_ASLD, OP_ASLDI: begin
                valid  = 1'b1;
                sat_ok = 1'b1;
            end
            // Rotates repeat with a 17-bit period, so their count is never clamped
            OP_RORW, OP_ROLW, OP_RORD, OP_RORDI, OP_ROLD, OP_ROLDI: begin
                valid  = 1'b1;
                sat_ok = 1'b0;
            end
            default: begin
                valid  = 1'b0;
                sat_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/jtkcpu_shseq.sv
// Multi-cycle shift/rotate sequencer: replays a one-bit ALU shift once per
// cycle for count-operand 16-bit shifts and returns the final value and CC.
module jtkcpu_shseq
    import jtkcpu_pkg::*;
#(
    parameter int SATCNT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    // start is a one-cycle request taken only in IDLE or DONE; done is a
    // one-cycle pulse and rslt/cc_out/err are valid while it is high.
    input  logic        start,
    input  logic [7:0]  op,
    input  logic [15:0] value,
    input  logic [7:0]  cnt,
    input  logic [7:0]  cc_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rslt,
    output logic [7:0]  cc_out,
    output logic [7:0]  alu_op,
    output logic [15:0] alu_opnd0,
    output logic [15:0] alu_opnd1,
    output logic [7:0]  alu_cc,
    input  logic [15:0] alu_rslt,
    input  logic [7:0]  alu_ccr,
    output logic [1:0]  dbg_state
);

    logic [1:0]  r_state;
    logic [7:0]  r_op;
    logic [15:0] r_acc;
    logic [7:0]  r_ccr;
    logic [7:0]  r_rem;
    logic [15:0] r_rslt;
    logic [7:0]  r_cc_out;
    logic        r_err;

    logic        w_valid;
    logic        w_sat_ok;
    logic        w_accept;
    logic [7:0]  w_eff_cnt;
    logic [7:0]  w_step_cc;

    jtkcpu_shseq_dec u_dec (
        .op     (op),
        .valid  (w_valid),
        .sat_ok (w_sat_ok)
    );

    assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);

    // Beyond 17 steps LSR/ASL/ASR results and flags no longer change
    always_comb begin
        w_eff_cnt = cnt;
        if (SATCNT != 0 && w_sat_ok && cnt > SAT_LIMIT)
            w_eff_cnt = SAT_LIMIT;
    end

    assign w_step_cc = cc_merge(alu_ccr, r_ccr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= 8'h00;
            r_acc    <= 16'h0000;
            r_ccr    <= 8'h00;
            r_rem    <= 8'h00;
            r_rslt   <= 16'h0000;
            r_cc_out <= 8'h00;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_op  <= op;
            r_acc <= value;
            r_ccr <= cc_in;
            r_err <= !w_valid;
            if (!w_valid || w_eff_cnt == 8'd0) begin
                r_rem    <= 8'd0;
                r_rslt   <= value;
                r_cc_out <= cc_in;
                r_state  <= ST_DONE;
            end else begin
                r_rem   <= w_eff_cnt;
                r_state <= ST_RUN;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_acc <= alu_rslt;
                    r_ccr <= w_step_cc;
                    r_rem <= r_rem - 8'd1;
                    if (r_rem == 8'd1) begin
                        r_rslt   <= alu_rslt;
                        r_cc_out <= w_step_cc;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign err       = (r_state == ST_DONE) && r_err;
    assign rslt      = r_rslt;
    assign cc_out    = r_cc_out;
    assign dbg_state = r_state;

    // ALU inputs come only from registers so each cycle is exactly one pass
    assign alu_op    = busy ? r_op  : 8'h00;
    assign alu_opnd0 = busy ? r_acc : 16'h0000;
    assign alu_cc    = busy ? r_ccr : 8'h00;
    assign alu_opnd1 = 16'h0000;

endmodule

// File: tb/tb_jtkcpu_shseq.sv
// Directed bench for jtkcpu_shseq with a behavioural one-bit shift ALU;
// covers a clamping and a non-clamping instance.
module tb_jtkcpu_shseq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s, start_n;
    logic [7:0]  op;
    logic [15:0] value;
    logic [7:0]  cnt;
    logic [7:0]  cc_in;

    logic        busy_s, done_s, err_s, busy_n, done_n, err_n;
    logic [15:0] rslt_s, rslt_n, opnd0_s, opnd0_n, opnd1_s, opnd1_n;
    logic [15:0] arslt_s, arslt_n;
    logic [7:0]  cco_s, cco_n, aop_s, aop_n, acc_s, acc_n, accr_s, accr_n;
    logic [1:0]  st_s, st_n;

    int checks = 0;
    int errors = 0;
    logic sel_n = 1'b0;
    logic [23:0] exp_q[$];

    logic [7:0]  first_op, first_cc;
    logic [15:0] first_opnd0, first_opnd1;

    always #5 clk = ~clk;

    // One-bit 16-bit shift ALU: C/V/N/Z updated, other CC bits passed through
    function automatic logic [23:0] alu_step(input logic [7:0] o, input logic [15:0] v,
                                             input logic [7:0] c);
        logic [15:0] r;
        logic [7:0]  f;
        r = v;
        f = c;
        case (o)
            8'hA3, 8'hB8, 8'hB9: begin r = {1'b0, v[15:1]};  f[0] = v[0]; end
            8'hA4, 8'hBA, 8'hBB: begin r = {c[0], v[15:1]};  f[0] = v[0]; end
            8'hA5, 8'hBC, 8'hBD: begin r = {v[15], v[15:1]}; f[0] = v[0]; end
            8'hA6, 8'hBE, 8'hBF: begin r = {v[14:0], 1'b0};  f[0] = v[15]; f[1] = v[15] ^ v[14]; end
            8'hA7, 8'hC0, 8'hC1: begin r = {v[14:0], c[0]};  f[0] = v[15]; f[1] = v[15] ^ v[14]; end
            default: begin r = v; f = c; end
        endcase
        f[3] = r[15];
        f[2] = (r == 16'h0000);
        return {f, r};
    endfunction

    assign {accr_s, arslt_s} = alu_step(aop_s, opnd0_s, acc_s);
    assign {accr_n, arslt_n} = alu_step(aop_n, opnd0_n, acc_n);

    jtkcpu_shseq #(.SATCNT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .op(op), .value(value), .cnt(cnt),
        .cc_in(cc_in), .busy(busy_s), .done(done_s), .err(err_s), .rslt(rslt_s),
        .cc_out(cco_s), .alu_op(aop_s), .alu_opnd0(opnd0_s), .alu_opnd1(opnd1_s),
        .alu_cc(acc_s), .alu_rslt(arslt_s), .alu_ccr(accr_s), .dbg_state(st_s)
    );

    jtkcpu_shseq #(.SATCNT(0)) u_nosat (
        .clk(clk), .rst_n(rst_n), .start(start_n), .op(op), .value(value), .cnt(cnt),
        .cc_in(cc_in), .busy(busy_n), .done(done_n), .err(err_n), .rslt(rslt_n),
        .cc_out(cco_n), .alu_op(aop_n), .alu_opnd0(opnd0_n), .alu_opnd1(opnd1_n),
        .alu_cc(acc_n), .alu_rslt(arslt_n), .alu_ccr(accr_n), .dbg_state(st_n)
    );

    logic        w_busy, w_done, w_err;
    logic [15:0] w_rslt;
    logic [7:0]  w_cc;
    assign w_busy = sel_n ? busy_n : busy_s;
    assign w_done = sel_n ? done_n : done_s;
    assign w_err  = sel_n ? err_n  : err_s;
    assign w_rslt = sel_n ? rslt_n : rslt_s;
    assign w_cc   = sel_n ? cco_n  : cco_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait for done; lat counts edges after the accepting edge
    task automatic run_op(input logic inst_n, input logic [7:0] o, input logic [15:0] v,
                          input logic [7:0] c, input logic [7:0] ccin,
                          output int lat, output int nb);
        sel_n = inst_n;
        @(negedge clk);
        op = o; value = v; cnt = c; cc_in = ccin;
        if (inst_n) start_n = 1'b1; else start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        start_n = 1'b0;
        first_op = aop_s; first_opnd0 = opnd0_s; first_opnd1 = opnd1_s; first_cc = acc_s;
        lat = 0;
        nb  = 0;
        while (!w_done && lat < 300) begin
            if (w_busy) nb++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_op(input string tag, input int lat, input int nb, input int exp_lat,
                            input logic [15:0] exp_r, input logic [7:0] exp_c, input logic exp_e);
        logic [23:0] e;
        exp_q.push_back({exp_c, exp_r});
        e = exp_q.pop_front();
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, nb, exp_lat);
        check({tag, "_rslt"}, w_rslt, e[15:0]);
        check({tag, "_cc_out"}, w_cc, e[23:16]);
        check({tag, "_err"}, w_err, exp_e);
        @(negedge clk);
        check({tag, "_done_drop"}, w_done, 1'b0);
        check({tag, "_rslt_hold"}, w_rslt, e[15:0]);
    endtask

    initial begin
        int lat, nb, seen;
        rst_n = 1'b0; start_s = 1'b0; start_n = 1'b0;
        op = 8'h00; value = 16'h0000; cnt = 8'h00; cc_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", st_s, 2'd0);
        check("reset_busy", busy_s, 1'b0);
        check("reset_done", done_s, 1'b0);
        check("reset_err", err_s, 1'b0);
        check("reset_rslt", rslt_s, 16'h0000);
        check("reset_cc", cco_s, 8'h00);
        check("idle_alu_op", aop_s, 8'h00);
        check("idle_alu_opnd0", opnd0_s, 16'h0000);
        check("idle_alu_cc", acc_s, 8'h00);
        rst_n = 1'b1;

        run_op(1'b0, 8'hB8, 16'h8001, 8'd1, 8'h00, lat, nb);
        check("lsr_alu_op", first_op, 8'hB8);
        check("lsr_alu_opnd0", first_opnd0, 16'h8001);
        check("lsr_alu_opnd1", first_opnd1, 16'h0000);
        check("lsr_alu_cc", first_cc, 8'h00);
        check_op("lsrd1", lat, nb, 1, 16'h4000, 8'h01, 1'b0);

        // Reset two cycles into a 10-step run
        sel_n = 1'b0;
        @(negedge clk);
        op = 8'hB8; value = 16'h1234; cnt = 8'd10; cc_in = 8'h00; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_run_busy", busy_s, 1'b0);
        check("rst_run_rslt", rslt_s, 16'h0000);
        check("rst_run_cc", cco_s, 8'h00);
        check("rst_run_state", st_s, 2'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_s) seen++;
        end
        check("rst_run_no_done", seen, 0);

        run_op(1'b0, 8'hBE, 16'hFFFF, 8'd200, 8'h00, lat, nb);
        check_op("asld_sat", lat, nb, 17, 16'h0000, 8'h04, 1'b0);
        run_op(1'b1, 8'hBE, 16'hFFFF, 8'd200, 8'h00, lat, nb);
        check_op("asld_nosat", lat, nb, 200, 16'h0000, 8'h04, 1'b0);
        run_op(1'b0, 8'hA3, 16'hFFFF, 8'd18, 8'h00, lat, nb);
        check_op("lsrw_sat", lat, nb, 17, 16'h0000, 8'h04, 1'b0);
        run_op(1'b0, 8'hBA, 16'h0001, 8'd17, 8'h00, lat, nb);
        check_op("rord17", lat, nb, 17, 16'h0001, 8'h00, 1'b0);
        run_op(1'b0, 8'hBA, 16'h0001, 8'd20, 8'h00, lat, nb);
        check_op("rord20_noclamp", lat, nb, 20, 16'h4000, 8'h00, 1'b0);
        run_op(1'b0, 8'hBC, 16'h8004, 8'd3, 8'hF0, lat, nb);
        check_op("asrd3", lat, nb, 3, 16'hF000, 8'hF9, 1'b0);
        run_op(1'b0, 8'hC0, 16'h8000, 8'd2, 8'h81, lat, nb);
        check_op("rold2", lat, nb, 2, 16'h0003, 8'h80, 1'b0);
        run_op(1'b0, 8'hB8, 16'hABCD, 8'd0, 8'h5A, lat, nb);
        check_op("zero_cnt", lat, nb, 0, 16'hABCD, 8'h5A, 1'b0);
        run_op(1'b0, 8'h12, 16'h1357, 8'd5, 8'h3C, lat, nb);
        check("bad_op_done", done_s, 1'b1);
        check_op("bad_op", lat, nb, 0, 16'h1357, 8'h3C, 1'b1);

        // Back-to-back: second start issued in the DONE cycle of the first
        run_op(1'b0, 8'hB8, 16'h8001, 8'd1, 8'h00, lat, nb);
        check("b2b_first_lat", lat, 1);
        check("b2b_first_rslt", rslt_s, 16'h4000);
        op = 8'hBC; value = 16'h8004; cnt = 8'd3; cc_in = 8'hF0; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check("b2b_busy", busy_s, 1'b1);
        check("b2b_alu_opnd0", opnd0_s, 16'h8004);
        lat = 0;
        nb = 0;
        while (!done_s && lat < 300) begin
            if (busy_s) nb++;
            @(negedge clk);
            lat++;
        end
        check_op("b2b_second", lat, nb, 3, 16'hF000, 8'hF9, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
